// File: rtl/wb_write_arbiter.sv
// Write-back arbiter: merges ALU results and FIFO-buffered load returns onto the single register-file write port.
// Latency: ALU result reaches the write port 1 cycle after transfer; a load 2 cycles after acceptance (no bypass).
// Backpressure: lsu_ready = !full; alu_ready drops only when the starvation limit forces the FIFO head through.
module wb_write_arbiter #(
   parameter int DEPTH        = 4,
   parameter int STARVE_LIMIT = 3
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        alu_valid,
   input  logic [4:0]  alu_rd,
   input  logic [31:0] alu_data,
   output logic        alu_ready,
   input  logic        lsu_valid,
   input  logic [4:0]  lsu_rd,
   input  logic [31:0] lsu_data,
   output logic        lsu_ready,
   input  logic        issue_valid,
   input  logic [4:0]  issue_rd,
   input  logic [4:0]  rs1,
   input  logic [4:0]  rs2,
   output logic        rs1_busy,
   output logic        rs2_busy,
   output logic        regwrite,
   output logic [4:0]  write_reg,
   output logic [31:0] write_data
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(STARVE_LIMIT + 1);

   // Load-return FIFO storage; entries are {rd, data}
   logic [36:0]   mem [DEPTH];
   logic [AW:0]   wptr;
   logic [AW:0]   rptr;
   logic          full;
   logic          empty;
   logic          push;
   logic          pop;
   logic          alu_xfer;
   logic [4:0]    head_rd;
   logic [31:0]   head_data;

   logic [CW-1:0] starve_cnt;
   logic          starve_stall;

   // Bit 0 (x0) is kept at zero so busy lookups need no special case
   logic [31:0]   pending;
   logic [31:0]   pending_next;

   // Full when the pointers address the same slot on different laps
   assign empty = (wptr == rptr);
   assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);

   assign {head_rd, head_data} = mem[rptr[AW-1:0]];

   assign starve_stall = (starve_cnt == CW'(STARVE_LIMIT));

   // Ready outputs depend only on registered state, never on the valids
   assign lsu_ready = !full;
   assign alu_ready = !(starve_stall && !empty);

   assign push     = lsu_valid && lsu_ready;
   assign alu_xfer = alu_valid && alu_ready;
   // While starving, alu_ready is low so alu_xfer is already 0; a non-empty FIFO
   // therefore pops whenever the ALU did not win this cycle.
   assign pop      = !empty && !alu_xfer;

   assign rs1_busy = pending[rs1];
   assign rs2_busy = pending[rs2];

   // FIFO payload write; storage needs no reset since pointers gate visibility
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wptr[AW-1:0]] <= {lsu_rd, lsu_data};
      end
   end

   // FIFO pointers advance on accepted pushes and arbitrated pops
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (push) wptr <= wptr + 1'b1;
         if (pop)  rptr <= rptr + 1'b1;
      end
   end

   // Count consecutive ALU wins over a waiting load; any pop or empty FIFO clears it
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         starve_cnt <= '0;
      end else if (alu_xfer && !empty) begin
         starve_cnt <= starve_cnt + 1'b1;
      end else begin
         starve_cnt <= '0;
      end
   end

   // Scoreboard update: clear on load write-back, then set on issue so set wins
   always_comb begin
      pending_next = pending;
      if (pop && (head_rd != 5'd0)) begin
         pending_next[head_rd] = 1'b0;
      end
      if (issue_valid && (issue_rd != 5'd0)) begin
         pending_next[issue_rd] = 1'b1;
      end
      pending_next[0] = 1'b0;
   end

   // Scoreboard register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending <= '0;
      end else begin
         pending <= pending_next;
      end
   end

   // Registered write port; x0 destinations consume the source without writing
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         regwrite   <= 1'b0;
         write_reg  <= '0;
         write_data <= '0;
      end else if (pop) begin
         regwrite   <= (head_rd != 5'd0);
         write_reg  <= head_rd;
         write_data <= head_data;
      end else if (alu_xfer) begin
         regwrite   <= (alu_rd != 5'd0);
         write_reg  <= alu_rd;
         write_data <= alu_data;
      end else begin
         regwrite   <= 1'b0;
      end
   end

endmodule

// File: doc/wb_write_arbiter.md
# wb_write_arbiter

Write-back arbiter that owns the register file's single write port. It merges single-cycle ALU results from the MEM/WB stage with long-latency load returns, buffering the load returns in a small FIFO. It issues at most one registered write per cycle (`regwrite` / `write_reg` / `write_data`). It also keeps a per-register pending scoreboard, so the hazard logic can stall readers of registers whose load has not yet been written back.

## Interface
Parameters:
- `DEPTH`, default 4: load-return FIFO entries; must be a power of two, at least 2.
- `STARVE_LIMIT`, default 3: consecutive cycles in which the ALU may occupy the write port while the FIFO is non-empty, before the FIFO is forced through.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `alu_valid`  in  1  ALU result present.
- `alu_rd`  in  5  ALU destination register.
- `alu_data`  in  32  ALU result.
- `alu_ready`  out  1  ALU result accepted this cycle; when low, the pipeline holds its ALU result.
- `lsu_valid`  in  1  load return present.
- `lsu_rd`  in  5  load destination register.
- `lsu_data`  in  32  load data.
- `lsu_ready`  out  1  FIFO can accept a load return.
- `issue_valid`  in  1  a load is issuing this cycle.
- `issue_rd`  in  5  destination register of the issuing load.
- `rs1`  in  5  source register query 1.
- `rs2`  in  5  source register query 2.
- `rs1_busy`  out  1  pending bit of `rs1`.
- `rs2_busy`  out  1  pending bit of `rs2`.
- `regwrite`  out  1  write enable to the register file.
- `write_reg`  out  5  write address to the register file.
- `write_data`  out  32  write data to the register file.

## Operation
- ALU transfer occurs when `alu_valid && alu_ready`. Load transfer occurs when `lsu_valid && lsu_ready`; it pushes `{lsu_rd, lsu_data}` into the FIFO.
- `lsu_ready = !full`. A push is refused when the FIFO is full, even if a pop occurs in the same cycle.
- Arbitration, once per cycle:
  - If `starve_stall` is set and the FIFO is non-empty, pop the FIFO head.
  - Otherwise, if there is an ALU transfer, write the ALU result.
  - Otherwise, if the FIFO is non-empty, pop the head.
  - Otherwise, no write.
- `alu_ready = !(starve_stall && !empty)`. This is combinational from registered state only; it has no path from `alu_valid`.
- Starvation counter:
  - Increments when the ALU wins while the FIFO is non-empty.
  - Clears on any FIFO pop or when the FIFO is empty.
  - `starve_stall` is set when the counter equals `STARVE_LIMIT`.
- Destination x0:
  - The selected source is still consumed (ALU transfer accepted, or FIFO popped).
  - `regwrite` stays 0 for that cycle.
  - Pending bits are never set for x0.
- Scoreboard, 31 bits (x1..x31):
  - Set on `issue_valid` with `issue_rd != 0`.
  - Cleared when a FIFO pop writes that rd.
  - If set and clear hit the same rd in one cycle, set wins.
  - The scoreboard counts one outstanding load per rd. The hazard unit stalls issue of a second load to a still-pending rd.
  - An ALU write to a pending rd is performed but does not clear the pending bit.
- Busy outputs are combinational: `rs1_busy = pending[rs1]`, `rs2_busy = pending[rs2]`, and both are 0 for x0. A bit cleared at edge N reads 0 after edge N.

## Timing
- Reset (asynchronous on `rst_n` low):
  - `regwrite`=0, `write_reg`=0, `write_data`=0.
  - FIFO empty, counter 0, scoreboard 0.
  - Hence `lsu_ready`=1, `alu_ready`=1, `rs*_busy`=0.
- Write outputs are registered.
  - A source selected in cycle N drives `regwrite`/`write_reg`/`write_data` during cycle N+1, for exactly one cycle.
  - The register file captures them on the falling edge within cycle N+1.
- Load latency: a load accepted at edge N with an idle ALU path is popped in cycle N+1 and appears on the write port in cycle N+2. There is no FIFO bypass.
- FIFO pointers are `$clog2(DEPTH)+1` bits; full/empty come from the MSB compare, and pointers wrap modulo 2·DEPTH.
- Reset asserted mid-operation drops all queued entries and pending bits immediately. No write completes after `rst_n` falls.

## Test plan
- Reset, then ALU x5=0x1234 → one cycle later `regwrite`=1, `write_reg`=5, `write_data`=0x00001234 for exactly one cycle.
- Issue load rd=7 → `rs1_busy` with `rs1`=7 reads 1. Return `lsu_data`=0xDEADBEEF → write x7 two cycles after acceptance; `rs1_busy` drops the cycle after the write is issued.
- `DEPTH`=4: push 5 loads with the ALU writing every cycle → `lsu_ready` goes 0 after the 4th push, and the 5th is held until a pop.
- ALU valid every cycle with one queued load, `STARVE_LIMIT`=3 → ALU wins 3 times, then `alu_ready`=0 for one cycle, the load writes, then `alu_ready` returns to 1.
- ALU write to x0 plus a load return to x0 → both consumed, `regwrite` never asserts, and no scoreboard bit is set.
- `rst_n` pulsed low with 3 entries queued and x9 pending → outputs 0 immediately, `rs*_busy`=0, and no write follows release.
